// File: rtl/sja_bus_target_pkg.sv
// sja_bus_target shared types and constants.
// FSM encoding, register map and bus control bundle.
package sja_bus_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_SEL  = 3'd2,
    ST_RD   = 3'd3,
    ST_WR   = 3'd4
  } state_e;

  localparam logic [7:0] REG_IR      = 8'h03;
  localparam logic [7:0] REG_IER     = 8'h04;
  localparam logic [7:0] UNIMP_RDATA = 8'hFF;

  typedef struct packed {
    logic ale;
    logic cs_n;
    logic rd_n;
    logic wr_n;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{
    ale:  1'b0,
    cs_n: 1'b1,
    rd_n: 1'b1,
    wr_n: 1'b1
  };

endpackage

// File: rtl/sja_bus_target_sync_nff.sv
// sync_nff: N-deep, W-wide input synchronizer.
// Reset loads RST_VAL so idle bus levels never look like edges.
module sync_nff #(
  parameter int         W       = 1,
  parameter int         STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sr[i] <= RST_VAL;
      end
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/sja_bus_target.sv
// sja_bus_target: SJA1000-style Intel-mode bus responder.
// Emulates a CAN-controller register window with IR/IER interrupt.
module sja_bus_target
  import sja_bus_target_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       SYSCLK,
  input  logic       SYSRST_N,
  input  logic       BUS_ALE,
  input  logic       BUS_CS_N,
  input  logic       BUS_RD_N,
  input  logic       BUS_WR_N,
  input  logic [7:0] AD_IN,
  output logic [7:0] AD_OUT,
  output logic       AD_OE,
  input  logic [7:0] EVT_IN,
  output logic       REG_WE,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       INT_N
);

  localparam int AW = $clog2(NREGS);

  bus_ctl_t   ctl_raw;
  bus_ctl_t   ctl_s;
  logic [7:0] ad_s;

  state_e     state_q;
  state_e     state_d;
  logic [7:0] addr_q;
  logic [7:0] addr_d;
  logic [7:0] rdata_q;
  logic [7:0] rd_val;
  logic [7:0] wdata_q;
  logic [7:0] ir_q;
  logic [7:0] ier_q;
  logic       int_n_q;
  logic       we_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       rd_exit;
  logic       wr_exit;
  logic       rd_load;
  logic       ir_clr;
  logic [7:0] mem_q [NREGS];

  function automatic logic implemented(input logic [7:0] a);
    return {1'b0, a} < 9'(NREGS);
  endfunction

  assign ctl_raw = '{
    ale:  BUS_ALE,
    cs_n: BUS_CS_N,
    rd_n: BUS_RD_N,
    wr_n: BUS_WR_N
  };

  sync_nff #(
    .W       (4),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (CTL_IDLE)
  ) u_sync_ctl (
    .clk   (SYSCLK),
    .rst_n (SYSRST_N),
    .d     (ctl_raw),
    .q     (ctl_s)
  );

  sync_nff #(
    .W       (8),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (8'h00)
  ) u_sync_ad (
    .clk   (SYSCLK),
    .rst_n (SYSRST_N),
    .d     (AD_IN),
    .q     (ad_s)
  );

  // In RD/WR the strobe was low on entry, so a high level is the rising edge.
  always_comb begin
    state_d = state_q;
    rd_exit = 1'b0;
    wr_exit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctl_s.ale) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (!ctl_s.ale) state_d = ST_SEL;
      end
      ST_SEL: begin
        if (ctl_s.ale) begin
          state_d = ST_ADDR;
        end else if (!ctl_s.cs_n && !ctl_s.wr_n) begin
          state_d = ST_WR;
        end else if (!ctl_s.cs_n && !ctl_s.rd_n) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (ctl_s.rd_n || ctl_s.cs_n) begin
          state_d = ST_SEL;
          rd_exit = 1'b1;
        end
      end
      ST_WR: begin
        if (ctl_s.wr_n || ctl_s.cs_n) begin
          state_d = ST_SEL;
          wr_exit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_d = (state_q == ST_ADDR) ? ad_s : addr_q;

  assign rd_load =
    ((state_d == ST_SEL) && (state_q != ST_SEL)) ||
    ((state_d == ST_RD) && (state_q == ST_SEL));

  always_comb begin
    rd_val = UNIMP_RDATA;
    if (implemented(addr_d)) begin
      unique case (1'b1)
        (addr_d == REG_IR):  rd_val = ir_q;
        (addr_d == REG_IER): rd_val = ier_q;
        default:             rd_val = mem_q[addr_d[AW-1:0]];
      endcase
    end
  end

  assign ir_clr = rd_exit && (addr_q == REG_IR);

  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= 8'h00;
      rdata_q     <= 8'h00;
      wdata_q     <= 8'h00;
      ir_q        <= 8'h00;
      ier_q       <= 8'h00;
      int_n_q     <= 1'b1;
      we_q        <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (rd_load) rdata_q <= rd_val;
      if ((state_q == ST_WR) && !wr_exit) wdata_q <= ad_s;
      // A same-cycle event wins over the read-clear.
      ir_q <= (ir_clr ? 8'h00 : ir_q) | EVT_IN;
      if (wr_exit && (addr_q == REG_IER)) ier_q <= wdata_q;
      int_n_q <= ~|(ir_q & ier_q);
      we_q    <= wr_exit;
      if (wr_exit) begin
        reg_addr_q  <= addr_q;
        reg_wdata_q <= wdata_q;
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
    if (!SYSRST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_exit && implemented(addr_q) &&
                 (addr_q != REG_IR) && (addr_q != REG_IER)) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  assign AD_OUT    = rdata_q;
  assign AD_OE     = ~BUS_CS_N & ~BUS_RD_N;
  assign REG_WE    = we_q;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign INT_N     = int_n_q;

endmodule

// File: tb/tb_sja_bus_target.sv
// tb_sja_bus_target: randomized bus master, reference model, scoreboard.
// Monitor pops expected writes/reads whenever the DUT presents them.
module tb_sja_bus_target;

  localparam int NREGS = 32;
  localparam int SYNC  = 2;

  logic       SYSCLK = 1'b0;
  logic       SYSRST_N;
  logic       BUS_ALE;
  logic       BUS_CS_N;
  logic       BUS_RD_N;
  logic       BUS_WR_N;
  logic [7:0] AD_IN;
  logic [7:0] AD_OUT;
  logic       AD_OE;
  logic [7:0] EVT_IN;
  logic       REG_WE;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       INT_N;

  sja_bus_target #(
    .NREGS       (NREGS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .SYSCLK    (SYSCLK),
    .SYSRST_N  (SYSRST_N),
    .BUS_ALE   (BUS_ALE),
    .BUS_CS_N  (BUS_CS_N),
    .BUS_RD_N  (BUS_RD_N),
    .BUS_WR_N  (BUS_WR_N),
    .AD_IN     (AD_IN),
    .AD_OUT    (AD_OUT),
    .AD_OE     (AD_OE),
    .EVT_IN    (EVT_IN),
    .REG_WE    (REG_WE),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .INT_N     (INT_N)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wexp_t;

  wexp_t      wq [$];
  logic [7:0] rq [$];
  logic       rd_sample;
  int         vectors;
  int         miscompares;

  logic [7:0] m_mem [256];
  logic [7:0] m_ir;
  logic [7:0] m_ier;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_ir  = 8'h00;
    m_ier = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    wq.push_back('{a: a, d: d});
    if (a < NREGS) begin
      if (a == 8'h04) m_ier = d;
      else if (a != 8'h03) m_mem[a] = d;
    end
  endtask

  task automatic model_read(input logic [7:0] a);
    logic [7:0] v;
    if (a >= NREGS) v = 8'hFF;
    else if (a == 8'h03) v = m_ir;
    else if (a == 8'h04) v = m_ier;
    else v = m_mem[a];
    rq.push_back(v);
    if (a == 8'h03) m_ir = 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  task automatic addr_phase(input logic [7:0] a, input bit fast);
    @(negedge SYSCLK);
    BUS_ALE = 1'b1;
    AD_IN   = a;
    tick(fast ? 2 : 3);
    BUS_ALE = 1'b0;
    tick(fast ? SYNC + 1 : SYNC + 2);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d,
                           input bit abort, input bit fast);
    addr_phase(a, fast);
    model_write(a, d);
    BUS_CS_N = 1'b0;
    BUS_WR_N = 1'b0;
    AD_IN    = d;
    tick(fast ? SYNC + 1 : SYNC + 3);
    if (abort) begin
      BUS_CS_N = 1'b1;
      tick(1);
    end
    BUS_WR_N = 1'b1;
    BUS_CS_N = 1'b1;
    tick(SYNC + 4);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] race,
                          input bit fast);
    addr_phase(a, fast);
    model_read(a);
    BUS_CS_N = 1'b0;
    BUS_RD_N = 1'b0;
    #1;
    chk("ad_oe_on", {7'd0, AD_OE}, 8'd1);
    tick(fast ? SYNC + 1 : SYNC + 3);
    rd_sample = 1'b1;
    tick(1);
    rd_sample = 1'b0;
    BUS_RD_N  = 1'b1;
    BUS_CS_N  = 1'b1;
    #1;
    chk("ad_oe_off", {7'd0, AD_OE}, 8'd0);
    // Land the event pulse on the clock edge where the IR clear commits.
    repeat (SYNC) @(posedge SYSCLK);
    @(negedge SYSCLK);
    EVT_IN = race;
    @(negedge SYSCLK);
    EVT_IN = 8'h00;
    m_ir = m_ir | race;
    tick(SYNC + 3);
  endtask

  task automatic evt_pulse(input logic [7:0] v);
    @(negedge SYSCLK);
    EVT_IN = v;
    @(negedge SYSCLK);
    EVT_IN = 8'h00;
    m_ir = m_ir | v;
  endtask

  task automatic check_int(input string nm);
    tick(3);
    chk(nm, {7'd0, INT_N}, {7'd0, ~|(m_ir & m_ier)});
  endtask

  initial begin : monitor
    wexp_t e;
    forever begin
      @(posedge SYSCLK);
      #1;
      if (REG_WE === 1'b1) begin
        if (wq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_reg_we: addr %h data %h, required none",
                   REG_ADDR, REG_WDATA);
        end else begin
          e = wq.pop_front();
          chk("reg_addr", REG_ADDR, e.a);
          chk("reg_wdata", REG_WDATA, e.d);
        end
      end
      if (rd_sample) begin
        if (rq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: ad_out %h, required none", AD_OUT);
        end else begin
          chk("ad_out", AD_OUT, rq.pop_front());
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] a;
    logic [7:0] d;
    vectors     = 0;
    miscompares = 0;
    rd_sample   = 1'b0;
    SYSRST_N    = 1'b0;
    BUS_ALE     = 1'b0;
    BUS_CS_N    = 1'b1;
    BUS_RD_N    = 1'b1;
    BUS_WR_N    = 1'b1;
    AD_IN       = 8'h00;
    EVT_IN      = 8'h00;
    model_reset();
    tick(3);
    chk("rst_int_n", {7'd0, INT_N}, 8'd1);
    chk("rst_reg_we", {7'd0, REG_WE}, 8'd0);
    chk("rst_ad_out", AD_OUT, 8'h00);
    SYSRST_N = 1'b1;
    tick(2);

    // Dirty state, then reset in the middle of a write.
    bus_write(8'h07, 8'h5A, 1'b0, 1'b0);
    bus_write(8'h04, 8'hFF, 1'b0, 1'b0);
    evt_pulse(8'h80);
    check_int("int_n_pre_rst");
    addr_phase(8'h09, 1'b0);
    BUS_CS_N = 1'b0;
    BUS_WR_N = 1'b0;
    AD_IN    = 8'h33;
    tick(2);
    SYSRST_N = 1'b0;
    #1;
    chk("mid_rst_int_n", {7'd0, INT_N}, 8'd1);
    chk("mid_rst_reg_we", {7'd0, REG_WE}, 8'd0);
    chk("mid_rst_reg_addr", REG_ADDR, 8'h00);
    chk("mid_rst_reg_wdata", REG_WDATA, 8'h00);
    chk("mid_rst_ad_out", AD_OUT, 8'h00);
    BUS_WR_N = 1'b1;
    BUS_RD_N = 1'b0;
    #1;
    chk("rst_ad_oe_pins", {7'd0, AD_OE}, 8'd1);
    tick(2);
    BUS_RD_N = 1'b1;
    BUS_CS_N = 1'b1;
    tick(2);
    model_reset();
    SYSRST_N = 1'b1;
    tick(2);
    for (int i = 0; i < NREGS; i++) bus_read(8'(i), 8'h00, 1'b1);
    check_int("int_n_post_rst");

    // Write / read back.
    bus_write(8'h10, 8'hA5, 1'b0, 1'b0);
    bus_read(8'h10, 8'h00, 1'b0);

    // Interrupt path and its latency.
    bus_write(8'h04, 8'h01, 1'b0, 1'b0);
    @(negedge SYSCLK);
    EVT_IN = 8'h01;
    @(posedge SYSCLK);
    #1;
    chk("int_n_after_1", {7'd0, INT_N}, 8'd1);
    @(negedge SYSCLK);
    EVT_IN = 8'h00;
    m_ir = m_ir | 8'h01;
    @(posedge SYSCLK);
    #1;
    chk("int_n_after_2", {7'd0, INT_N}, 8'd0);
    bus_read(8'h03, 8'h00, 1'b0);
    check_int("int_n_after_clr");
    bus_read(8'h03, 8'h00, 1'b0);

    // Event racing the read-clear.
    evt_pulse(8'h01);
    bus_read(8'h03, 8'h02, 1'b0);
    bus_read(8'h03, 8'h00, 1'b0);
    check_int("int_n_race");

    // Out of range must not alias onto index 0.
    bus_write(8'h00, 8'h11, 1'b0, 1'b0);
    bus_write(8'h40, 8'h55, 1'b0, 1'b0);
    bus_read(8'h40, 8'h00, 1'b0);
    bus_read(8'h00, 8'h00, 1'b0);

    // Minimum timing, re-latched address, aborted write.
    bus_write(8'h05, 8'hC3, 1'b0, 1'b1);
    bus_write(8'h06, 8'h3C, 1'b0, 1'b1);
    bus_read(8'h05, 8'h00, 1'b1);
    addr_phase(8'h05, 1'b1);
    bus_read(8'h06, 8'h00, 1'b1);
    bus_write(8'h08, 8'h77, 1'b1, 1'b1);
    bus_read(8'h08, 8'h00, 1'b1);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 47));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(3, 4));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: bus_write(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: bus_read(a, 8'h00, 1'($urandom_range(0, 1)));
        default: evt_pulse(d);
      endcase
      check_int("int_n_rand");
    end

    tick(10);
    chk("wq_drained", 8'(wq.size()), 8'd0);
    chk("rq_drained", 8'(rq.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
